// File: rtl/fft_frame_sequencer_if.sv
// Stream bundle between the frame sequencer, its upstream sample source and the FFT core
// sink, plus the snooped FFT source handshake.
interface fft_frame_sequencer_if #(
   parameter int DATA_W = 14,
   parameter int PTS_W  = 11
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_real;
   logic [DATA_W-1:0] in_imag;

   logic              sink_valid;
   logic              sink_ready;
   logic              sink_sop;
   logic              sink_eop;
   logic [1:0]        sink_error;
   logic [DATA_W-1:0] sink_real;
   logic [DATA_W-1:0] sink_imag;
   logic [PTS_W-1:0]  fftpts_in;
   logic              inverse;

   logic              mon_src_valid;
   logic              mon_src_ready;
   logic              mon_src_eop;
   logic [1:0]        mon_src_error;

   modport master (
      input  in_valid, in_real, in_imag, sink_ready,
             mon_src_valid, mon_src_ready, mon_src_eop, mon_src_error,
      output in_ready, sink_valid, sink_sop, sink_eop, sink_error,
             sink_real, sink_imag, fftpts_in, inverse
   );

   modport slave (
      output in_valid, in_real, in_imag, sink_ready,
             mon_src_valid, mon_src_ready, mon_src_eop, mon_src_error,
      input  in_ready, sink_valid, sink_sop, sink_eop, sink_error,
             sink_real, sink_imag, fftpts_in, inverse
   );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Cuts a continuous sample stream into FFT frames of the configured size and throttles
// frame issue against the number of frames still held inside the FFT core.
module fft_frame_sequencer #(
   parameter int DATA_W       = 14,
   parameter int PTS_W        = 11,
   parameter int MAX_INFLIGHT = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  run,
   input  logic [PTS_W-1:0]      cfg_fftpts,
   input  logic                  cfg_inverse,
   input  logic                  err_clr,
   fft_frame_sequencer_if.master bus,
   output logic                  busy,
   output logic [1:0]            inflight,
   output logic [15:0]           frame_count,
   output logic                  err_cfg,
   output logic                  err_fft
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STREAM} state_t;

   localparam logic [1:0] MAX_Q = 2'(MAX_INFLIGHT);

   state_t           state_q, state_d;
   logic [PTS_W-1:0] cnt_q, cnt_d;
   logic [PTS_W-1:0] fftpts_q, fftpts_d;
   logic             inv_q, inv_d;
   logic [1:0]       inflight_q, inflight_d;
   logic [15:0]      fcount_q, fcount_d;
   logic             err_cfg_q, err_cfg_d;
   logic             err_fft_q, err_fft_d;

   logic cfg_legal;
   logic sink_valid, in_ready, sop, eop;
   logic beat, eop_beat, done, start;
   logic latch, cfg_err_set;

   always_comb begin
      case (cfg_fftpts)
         PTS_W'(64), PTS_W'(128), PTS_W'(256), PTS_W'(512), PTS_W'(1024): cfg_legal = 1'b1;
         default: cfg_legal = 1'b0;
      endcase
   end

   assign beat     = sink_valid & bus.sink_ready;
   assign eop_beat = beat & eop;
   assign done     = bus.mon_src_valid & bus.mon_src_ready & bus.mon_src_eop;

   // Start is judged against the occupancy after this cycle's issue/retire events.
   always_comb begin
      inflight_d = inflight_q;
      if (eop_beat && !done) begin
         inflight_d = inflight_q + 2'd1;
      end else if (done && !eop_beat && (inflight_q != 2'd0)) begin
         inflight_d = inflight_q - 2'd1;
      end
   end

   assign start = run & cfg_legal & (inflight_d < MAX_Q);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      latch       = 1'b0;
      cfg_err_set = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run && !cfg_legal) begin
               cfg_err_set = 1'b1;
            end else if (start) begin
               state_d = S_STREAM;
               latch   = 1'b1;
            end else if (run) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (start) begin
               state_d = S_STREAM;
               latch   = 1'b1;
            end else if (!run) begin
               state_d = S_IDLE;
            end
         end
         S_STREAM: begin
            if (eop_beat) begin
               if (start) begin
                  latch = 1'b1;
               end else if (run && cfg_legal) begin
                  state_d = S_WAIT;
               end else begin
                  state_d     = S_IDLE;
                  cfg_err_set = run & ~cfg_legal;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      sink_valid = 1'b0;
      in_ready   = 1'b0;
      sop        = 1'b0;
      eop        = 1'b0;
      if (state_q == S_STREAM) begin
         sink_valid = bus.in_valid;
         in_ready   = bus.sink_ready;
         sop        = (cnt_q == '0);
         eop        = (cnt_q == fftpts_q - PTS_W'(1));
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (beat) begin
         cnt_d = eop ? '0 : cnt_q + PTS_W'(1);
      end
      fftpts_d  = latch ? cfg_fftpts  : fftpts_q;
      inv_d     = latch ? cfg_inverse : inv_q;
      fcount_d  = fcount_q + 16'(eop_beat);
      // Set conditions dominate a same-cycle clear.
      err_cfg_d = cfg_err_set | (err_cfg_q & ~err_clr);
      err_fft_d = (bus.mon_src_valid & (bus.mon_src_error != 2'b00)) | (err_fft_q & ~err_clr);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q      <= '0;
         fftpts_q   <= PTS_W'(1024);
         inv_q      <= 1'b0;
         inflight_q <= '0;
         fcount_q   <= '0;
         err_cfg_q  <= 1'b0;
         err_fft_q  <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         fftpts_q   <= fftpts_d;
         inv_q      <= inv_d;
         inflight_q <= inflight_d;
         fcount_q   <= fcount_d;
         err_cfg_q  <= err_cfg_d;
         err_fft_q  <= err_fft_d;
      end
   end

   assign bus.sink_valid = sink_valid;
   assign bus.in_ready   = in_ready;
   assign bus.sink_sop   = sop;
   assign bus.sink_eop   = eop;
   assign bus.sink_error = 2'b00;
   assign bus.sink_real  = DATA_W'(bus.in_real);
   assign bus.sink_imag  = DATA_W'(bus.in_imag);
   assign bus.fftpts_in  = fftpts_q;
   assign bus.inverse    = inv_q;

   assign busy        = (state_q != S_IDLE);
   assign inflight    = inflight_q;
   assign frame_count = fcount_q;
   assign err_cfg     = err_cfg_q;
   assign err_fft     = err_fft_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Self-checking bench for fft_frame_sequencer: directed frame scenarios plus a randomized
// stall run compared against a frame-position / occupancy reference model.
`timescale 1ns/1ps
module tb_fft_frame_sequencer;
   localparam int DATA_W       = 14;
   localparam int PTS_W        = 11;
   localparam int MAX_INFLIGHT = 2;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             run;
   logic [PTS_W-1:0] cfg_fftpts;
   logic             cfg_inverse;
   logic             err_clr;
   logic             busy;
   logic [1:0]       inflight;
   logic [15:0]      frame_count;
   logic             err_cfg;
   logic             err_fft;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned up_idx   = 0;
   logic        acc_seen = 1'b0;

   fft_frame_sequencer_if #(.DATA_W(DATA_W), .PTS_W(PTS_W)) bus ();

   fft_frame_sequencer #(
      .DATA_W(DATA_W), .PTS_W(PTS_W), .MAX_INFLIGHT(MAX_INFLIGHT)
   ) dut (
      .clk(clk), .reset_n(reset_n), .run(run), .cfg_fftpts(cfg_fftpts),
      .cfg_inverse(cfg_inverse), .err_clr(err_clr), .bus(bus), .busy(busy),
      .inflight(inflight), .frame_count(frame_count), .err_cfg(err_cfg), .err_fft(err_fft)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] smp_re(input int unsigned i);
      return DATA_W'(i * 37 + 5);
   endfunction

   function automatic logic [DATA_W-1:0] smp_im(input int unsigned i);
      return DATA_W'(i * 113 + 9001);
   endfunction

   // Upstream source: presents sample up_idx and advances only when it is accepted.
   assign bus.in_real = smp_re(up_idx);
   assign bus.in_imag = smp_im(up_idx);
   always @(negedge clk) acc_seen = bus.in_valid & bus.in_ready;
   always @(posedge clk) if (acc_seen) up_idx <= up_idx + 1;

   task automatic drive_idle();
      run = 1'b0; cfg_fftpts = 11'd64; cfg_inverse = 1'b0; err_clr = 1'b0;
      bus.in_valid = 1'b0; bus.sink_ready = 1'b0;
      bus.mon_src_valid = 1'b0; bus.mon_src_ready = 1'b0; bus.mon_src_eop = 1'b0;
      bus.mon_src_error = 2'b00;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      drive_idle();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic pulse_done();
      @(posedge clk); #1;
      bus.mon_src_valid = 1'b1; bus.mon_src_ready = 1'b1; bus.mon_src_eop = 1'b1;
      @(posedge clk); #1;
      bus.mon_src_valid = 1'b0; bus.mon_src_ready = 1'b0; bus.mon_src_eop = 1'b0;
   endtask

   task automatic test_reset();
      logic [11:0] v;
      @(posedge clk); #1;
      reset_n = 1'b0; run = 1'b1; cfg_fftpts = 11'd64;
      bus.in_valid = 1'b1; bus.sink_ready = 1'b1;
      bus.mon_src_valid = 1'b1; bus.mon_src_error = 2'b01;
      repeat (3) @(posedge clk);
      @(negedge clk);
      v = {busy, bus.sink_valid, bus.in_ready, bus.sink_sop, bus.sink_eop, inflight,
           err_cfg, err_fft, bus.inverse, bus.sink_error};
      n_checks++;
      if (v !== 12'h000) begin
         n_fail++; $display("FAIL reset_flags: got %03h expected 000", v);
      end
      n_checks++;
      if (bus.fftpts_in !== 11'd1024) begin
         n_fail++; $display("FAIL reset_fftpts: got %0d expected 1024", bus.fftpts_in);
      end
      n_checks++;
      if (frame_count !== 16'd0) begin
         n_fail++; $display("FAIL reset_frame_count: got %0d expected 0", frame_count);
      end
      drive_idle();
   endtask

   task automatic test_back_to_back();
      int sops[$];
      int eops[$];
      int beats;
      do_reset();
      @(posedge clk); #1;
      cfg_fftpts = 11'd64; bus.in_valid = 1'b1; bus.sink_ready = 1'b1; run = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.sink_valid !== 1'b0) begin
         n_fail++; $display("FAIL b2b_latency: sink_valid=%0b before first edge, expected 0", bus.sink_valid);
      end
      beats = 0;
      for (int c = 0; c < 128; c++) begin
         @(negedge clk);
         if (bus.sink_valid && bus.sink_ready) begin
            if (bus.sink_sop) sops.push_back(beats);
            if (bus.sink_eop) eops.push_back(beats);
            beats++;
         end
      end
      n_checks++;
      if (beats != 128) begin
         n_fail++; $display("FAIL b2b_beats: got %0d beats in 128 cycles expected 128", beats);
      end
      n_checks++;
      if (sops.size() != 2 || sops[0] != 0 || sops[1] != 64) begin
         n_fail++;
         $display("FAIL b2b_sop: got %0d sops first=%0d second=%0d expected 2 at 0,64", sops.size(),
                  (sops.size() > 0) ? sops[0] : -1, (sops.size() > 1) ? sops[1] : -1);
      end
      n_checks++;
      if (eops.size() != 2 || eops[0] != 63 || eops[1] != 127) begin
         n_fail++;
         $display("FAIL b2b_eop: got %0d eops first=%0d second=%0d expected 2 at 63,127", eops.size(),
                  (eops.size() > 0) ? eops[0] : -1, (eops.size() > 1) ? eops[1] : -1);
      end
      @(negedge clk);
      n_checks++;
      if ({busy, bus.sink_valid, inflight, frame_count} !== {1'b1, 1'b0, 2'd2, 16'd2}) begin
         n_fail++;
         $display("FAIL b2b_wait: busy=%0b valid=%0b inflight=%0d frames=%0d expected 1,0,2,2",
                  busy, bus.sink_valid, inflight, frame_count);
      end
      pulse_done();
      @(negedge clk);
      n_checks++;
      if ({bus.sink_sop, bus.sink_valid} !== 2'b11) begin
         n_fail++; $display("FAIL b2b_third_sop: sop=%0b valid=%0b expected 1,1", bus.sink_sop, bus.sink_valid);
      end
      beats = 0;
      for (int c = 0; c < 80 && beats < 64; c++) begin
         if (c != 0) @(negedge clk);
         if (bus.sink_valid && bus.sink_ready) beats++;
      end
      @(negedge clk);
      n_checks++;
      if ({beats, inflight, frame_count, bus.sink_valid} !== {32'd64, 2'd2, 16'd3, 1'b0}) begin
         n_fail++;
         $display("FAIL b2b_third_frame: beats=%0d inflight=%0d frames=%0d valid=%0b expected 64,2,3,0",
                  beats, inflight, frame_count, bus.sink_valid);
      end
      drive_idle();
   endtask

   task automatic test_random_stalls();
      int unsigned N = 256;
      int unsigned k, frames, m_infl, idx;
      logic b, a, d, eop_b, pulse;
      do_reset();
      idx = up_idx; k = 0; frames = 0; m_infl = 0;
      @(posedge clk); #1;
      cfg_fftpts = 11'd256; run = 1'b1;
      bus.in_valid = 1'b1; bus.sink_ready = 1'b1;
      for (int cyc = 0; cyc < 8000 && frames < 3; cyc++) begin
         @(negedge clk);
         b = bus.sink_valid & bus.sink_ready;
         a = bus.in_valid & bus.in_ready;
         d = bus.mon_src_valid & bus.mon_src_ready & bus.mon_src_eop;
         n_checks++;
         if (a !== b) begin
            n_fail++; $display("FAIL rs_accept: upstream accept=%0b sink beat=%0b expected equal", a, b);
         end
         if (k != 0) begin
            n_checks++;
            if ({bus.sink_sop, bus.sink_eop, bus.fftpts_in} !== {1'b0, (k == N - 1), 11'd256}) begin
               n_fail++;
               $display("FAIL rs_hold: pos=%0d sop=%0b eop=%0b pts=%0d expected 0,%0b,256",
                        k, bus.sink_sop, bus.sink_eop, bus.fftpts_in, (k == N - 1));
            end
         end
         if (b) begin
            n_checks++;
            if ({bus.sink_sop, bus.sink_eop} !== {(k == 0), (k == N - 1)}) begin
               n_fail++;
               $display("FAIL rs_delim: pos=%0d sop=%0b eop=%0b", k, bus.sink_sop, bus.sink_eop);
            end
            n_checks++;
            if ({bus.sink_real, bus.sink_imag} !== {smp_re(idx), smp_im(idx)}) begin
               n_fail++;
               $display("FAIL rs_data: sample %0d got %0h/%0h expected %0h/%0h", idx,
                        bus.sink_real, bus.sink_imag, smp_re(idx), smp_im(idx));
            end
         end
         n_checks++;
         if ({inflight, frame_count} !== {2'(m_infl), 16'(frames)}) begin
            n_fail++;
            $display("FAIL rs_counts: inflight=%0d frames=%0d expected %0d,%0d",
                     inflight, frame_count, m_infl, frames);
         end
         @(posedge clk);
         eop_b = b && (k == N - 1);
         if (b) begin
            idx++;
            k = eop_b ? 0 : k + 1;
            if (eop_b) frames++;
         end
         if (eop_b && !d) m_infl++;
         else if (d && !eop_b && m_infl > 0) m_infl--;
         #1;
         bus.in_valid   = ($urandom_range(0, 9) < 7);
         bus.sink_ready = ($urandom_range(0, 9) < 7);
         pulse = (m_infl > 0) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 49) == 0);
         bus.mon_src_valid = pulse; bus.mon_src_ready = pulse; bus.mon_src_eop = pulse;
      end
      n_checks++;
      if (frames != 3) begin
         n_fail++; $display("FAIL rs_timeout: got %0d frames expected 3", frames);
      end
      drive_idle();
   endtask

   task automatic test_cfg_change();
      int beats;
      logic got_second;
      do_reset();
      @(posedge clk); #1;
      cfg_fftpts = 11'd256; cfg_inverse = 1'b0; run = 1'b1;
      bus.in_valid = 1'b1; bus.sink_ready = 1'b1;
      beats = 0; got_second = 1'b0;
      for (int c = 0; c < 700 && !got_second; c++) begin
         @(negedge clk);
         if (bus.sink_valid && bus.sink_ready) begin
            if (beats < 256) begin
               n_checks++;
               if ({bus.fftpts_in, bus.inverse, bus.sink_eop} !== {11'd256, 1'b0, (beats == 255)}) begin
                  n_fail++;
                  $display("FAIL cc_hold: beat %0d pts=%0d inv=%0b eop=%0b expected 256,0,%0b",
                           beats, bus.fftpts_in, bus.inverse, bus.sink_eop, (beats == 255));
               end
            end else begin
               n_checks++;
               if ({bus.sink_sop, bus.fftpts_in, bus.inverse} !== {1'b1, 11'd1024, 1'b1}) begin
                  n_fail++;
                  $display("FAIL cc_relatch: sop=%0b pts=%0d inv=%0b expected 1,1024,1",
                           bus.sink_sop, bus.fftpts_in, bus.inverse);
               end
               got_second = 1'b1;
            end
            beats++;
         end
         @(posedge clk); #1;
         if (beats == 100) begin
            cfg_fftpts = 11'd1024; cfg_inverse = 1'b1;
         end
      end
      n_checks++;
      if (!got_second) begin
         n_fail++; $display("FAIL cc_timeout: got %0d beats expected second frame start", beats);
      end
      drive_idle();
   endtask

   task automatic test_illegal_cfg();
      int unsigned bad_list[5] = '{100, 0, 63, 1023, 2047};
      do_reset();
      foreach (bad_list[i]) begin
         @(posedge clk); #1;
         run = 1'b1; err_clr = 1'b0; cfg_fftpts = PTS_W'(bad_list[i]); bus.in_valid = 1'b1;
         repeat (2) @(posedge clk);
         @(negedge clk);
         n_checks++;
         if ({err_cfg, busy, bus.sink_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL ic_detect: cfg=%0d err=%0b busy=%0b valid=%0b expected 1,0,0",
                     bad_list[i], err_cfg, busy, bus.sink_valid);
         end
         @(posedge clk); #1;
         err_clr = 1'b1;
         @(posedge clk); @(negedge clk);
         n_checks++;
         if (err_cfg !== 1'b1) begin
            n_fail++; $display("FAIL ic_set_wins: err_cfg=%0b expected 1", err_cfg);
         end
         @(posedge clk); #1;
         run = 1'b0;
         @(posedge clk); @(negedge clk);
         n_checks++;
         if (err_cfg !== 1'b0) begin
            n_fail++; $display("FAIL ic_clear: err_cfg=%0b expected 0", err_cfg);
         end
      end
      @(posedge clk); #1;
      err_clr = 1'b0; bus.mon_src_valid = 1'b0; bus.mon_src_error = 2'b10;
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (err_fft !== 1'b0) begin
         n_fail++; $display("FAIL fe_novalid: err_fft=%0b expected 0", err_fft);
      end
      @(posedge clk); #1;
      bus.mon_src_valid = 1'b1; bus.mon_src_error = 2'b01;
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (err_fft !== 1'b1) begin
         n_fail++; $display("FAIL fe_set: err_fft=%0b expected 1", err_fft);
      end
      @(posedge clk); #1;
      bus.mon_src_error = 2'b11; err_clr = 1'b1;
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (err_fft !== 1'b1) begin
         n_fail++; $display("FAIL fe_set_wins: err_fft=%0b expected 1", err_fft);
      end
      @(posedge clk); #1;
      bus.mon_src_error = 2'b00;
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (err_fft !== 1'b0) begin
         n_fail++; $display("FAIL fe_clear: err_fft=%0b expected 0", err_fft);
      end
      @(posedge clk); #1;
      err_clr = 1'b0; bus.mon_src_valid = 1'b0; bus.in_valid = 1'b0;
      run = 1'b1; cfg_fftpts = 11'd1024;
      @(posedge clk); @(negedge clk);
      n_checks++;
      if ({busy, err_cfg} !== 2'b10) begin
         n_fail++; $display("FAIL ic_legal_1024: busy=%0b err_cfg=%0b expected 1,0", busy, err_cfg);
      end
      drive_idle();
   endtask

   task automatic test_reset_midframe();
      int beats;
      logic [11:0] v;
      do_reset();
      @(posedge clk); #1;
      cfg_fftpts = 11'd64; run = 1'b1; bus.in_valid = 1'b1; bus.sink_ready = 1'b1;
      beats = 0;
      for (int c = 0; c < 200 && beats < 94; c++) begin
         @(negedge clk);
         if (bus.sink_valid && bus.sink_ready) beats++;
      end
      n_checks++;
      if ({beats, frame_count, inflight} !== {32'd94, 16'd1, 2'd1}) begin
         n_fail++;
         $display("FAIL rm_before: beats=%0d frames=%0d inflight=%0d expected 94,1,1",
                  beats, frame_count, inflight);
      end
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(posedge clk); @(negedge clk);
      v = {busy, bus.sink_valid, bus.in_ready, bus.sink_sop, bus.sink_eop, inflight,
           err_cfg, err_fft, bus.inverse, bus.sink_error};
      n_checks++;
      if ({v, bus.fftpts_in, frame_count} !== {12'h000, 11'd1024, 16'd0}) begin
         n_fail++;
         $display("FAIL rm_reset: flags=%03h pts=%0d frames=%0d expected 000,1024,0",
                  v, bus.fftpts_in, frame_count);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); @(negedge clk);
      n_checks++;
      if ({bus.sink_sop, bus.sink_valid, bus.fftpts_in} !== {1'b1, 1'b1, 11'd64}) begin
         n_fail++;
         $display("FAIL rm_restart: sop=%0b valid=%0b pts=%0d expected 1,1,64",
                  bus.sink_sop, bus.sink_valid, bus.fftpts_in);
      end
      beats = 0;
      for (int c = 0; c < 80 && beats < 64; c++) begin
         if (c != 0) @(negedge clk);
         if (bus.sink_valid && bus.sink_ready) begin
            beats++;
            n_checks++;
            if (bus.sink_eop !== (beats == 64)) begin
               n_fail++;
               $display("FAIL rm_eop: beat %0d eop=%0b expected %0b", beats - 1, bus.sink_eop, (beats == 64));
            end
         end
      end
      @(negedge clk);
      n_checks++;
      if (frame_count !== 16'd1) begin
         n_fail++; $display("FAIL rm_count: frames=%0d expected 1", frame_count);
      end
      drive_idle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      drive_idle();
      test_reset();
      test_back_to_back();
      test_random_stalls();
      test_cfg_change();
      test_illegal_cfg();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
